// File: rtl/fifo_arb_pkg.sv
// Purpose: shared types and default sizing for the FIFO write-port arbiter.
//   arb_state_e - arbiter state encoding (IDLE / GRANT)
//   DSIZE_DEF   - default data word width
//   NREQ_DEF    - default number of requesters
//   WCNT_W      - width of the written-word counter
package fifo_arb_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WCNT_W    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_rr_pick.sv
// Purpose: combinational rotating-priority search. Finds the first set bit of
// i_req starting at (i_last+1) mod NREQ and wrapping upward.
// Ports:
//   i_req   - request vector, one bit per requester
//   i_last  - index of the most recent grantee (lowest priority)
//   o_found - at least one request bit is set
//   o_idx   - selected requester index (0 when nothing found)
module fifo_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic            o_found,
  output logic [IW-1:0]   o_idx
);

  // Walk offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      j = (int'(i_last) + k) % int'(NREQ);
      if (i_req[IW'(j)]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Purpose: shares one FIFO write port among NREQ requesters with
// packet-granular round-robin arbitration. A grant is held from the first
// word until the word flagged last has been written.
// Ports:
//   wclk, wrst_n - write-domain clock, async active-low reset
//   req_valid    - per-requester word valid
//   req_last     - per-requester last word of packet
//   req_data     - packed words, requester k at [k*DSIZE +: DSIZE]
//   req_ready    - per-requester word accepted (combinational)
//   winc, wdata  - FIFO write enable / data (combinational)
//   wfull        - FIFO full flag
//   busy         - a packet grant is held (registered)
//   gnt_id       - current or most recent grantee (registered)
//   wr_count     - words written since reset, wraps (registered)
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IW    = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  output logic                  busy,
  output logic [IW-1:0]         gnt_id,
  output logic [WCNT_W-1:0]     wr_count
);

  arb_state_e          r_state;
  logic [IW-1:0]       r_gnt_id;
  logic [IW-1:0]       r_last_gnt;
  logic                r_busy;
  logic [WCNT_W-1:0]   r_wr_count;

  logic                w_found;
  logic [IW-1:0]       w_pick;
  logic                w_grant;
  logic                w_winc;
  logic [DSIZE-1:0]    w_slice;
  logic [NREQ-1:0]     w_ready;

  fifo_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_last  (r_last_gnt),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Data slice of the current grantee.
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (r_gnt_id == IW'(k)) begin
        w_slice = req_data[k*DSIZE +: DSIZE];
      end
    end
  end

  assign w_grant = (r_state == ST_GRANT);
  assign w_winc  = w_grant & req_valid[r_gnt_id] & ~wfull;

  // Only the grantee sees ready, and only while the FIFO has room.
  always_comb begin
    w_ready = '0;
    if (w_grant && !wfull) begin
      w_ready[r_gnt_id] = 1'b1;
    end
  end

  assign req_ready = w_ready;
  assign winc      = w_winc;
  assign wdata     = w_grant ? w_slice : '0;
  assign busy      = r_busy;
  assign gnt_id    = r_gnt_id;
  assign wr_count  = r_wr_count;

  // Arbiter FSM and write counter. After reset requester 0 has top priority.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= ST_IDLE;
      r_gnt_id   <= '0;
      r_last_gnt <= IW'(NREQ - 1);
      r_busy     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt_id <= w_pick;
            r_busy   <= 1'b1;
            r_state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_winc && req_last[r_gnt_id]) begin
            r_last_gnt <= r_gnt_id;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
      if (w_winc) begin
        r_wr_count <= r_wr_count + WCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: reset, single packet, round-robin order,
// full back-pressure, mid-packet reset and counter wrap.
module tb_fifo_wr_arb;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IW    = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic                  busy;
  logic [IW-1:0]         gnt_id;
  logic [15:0]           wr_count;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .busy      (busy),
    .gnt_id    (gnt_id),
    .wr_count  (wr_count)
  );

  always #5 wclk = ~wclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DSIZE-1:0] v);
    req_data[k*DSIZE +: DSIZE] = v;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;

    // Reset with every requester valid.
    #3;
    check_eq("rst_winc",  32'(winc), 32'h0);
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_busy",  32'(busy), 32'h0);
    check_eq("rst_gnt",   32'(gnt_id), 32'h0);
    check_eq("rst_cnt",   32'(wr_count), 32'h0);
    check_eq("rst_wdata", 32'(wdata), 32'h0);
    tick();
    tick();
    req_valid = '0;
    wrst_n    = 1'b1;

    // Requester 2: A1, A2, A3(last).
    req_valid[2] = 1'b1;
    set_data(2, 8'hA1);
    #1;
    check_eq("p2_idle_winc", 32'(winc), 32'h0);
    tick();
    #1;
    check_eq("p2_gnt",   32'(gnt_id), 32'h2);
    check_eq("p2_busy",  32'(busy), 32'h1);
    check_eq("p2_ready", 32'(req_ready), 32'h4);
    check_eq("p2_w1",    32'(winc), 32'h1);
    check_eq("p2_d1",    32'(wdata), 32'hA1);
    tick();
    set_data(2, 8'hA2);
    #1;
    check_eq("p2_w2", 32'(winc), 32'h1);
    check_eq("p2_d2", 32'(wdata), 32'hA2);
    check_eq("p2_c1", 32'(wr_count), 32'h1);
    tick();
    set_data(2, 8'hA3);
    req_last[2] = 1'b1;
    #1;
    check_eq("p2_w3", 32'(winc), 32'h1);
    check_eq("p2_d3", 32'(wdata), 32'hA3);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check_eq("p2_busy_end",  32'(busy), 32'h0);
    check_eq("p2_winc_end",  32'(winc), 32'h0);
    check_eq("p2_wdata_end", 32'(wdata), 32'h0);
    check_eq("p2_cnt",       32'(wr_count), 32'h3);

    // Round robin from reset: four one-word requesters, order 0,1,2,3,0,1.
    do_reset();
    req_valid = '1;
    req_last  = '1;
    for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 + k));
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      check_eq("rr_gnt",   32'(gnt_id), 32'(i % 4));
      check_eq("rr_winc",  32'(winc), 32'h1);
      check_eq("rr_wdata", 32'(wdata), 32'(8'h10 + (i % 4)));
      check_eq("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      #1;
      check_eq("rr_gap_winc", 32'(winc), 32'h0);
      check_eq("rr_gap_busy", 32'(busy), 32'h0);
    end
    check_eq("rr_cnt", 32'(wr_count), 32'h6);
    req_valid = '0;
    req_last  = '0;

    // Back-pressure: wfull for 5 cycles after the second of four words.
    do_reset();
    req_valid[2] = 1'b1;
    set_data(2, 8'hB1);
    tick();
    #1;
    check_eq("bp_gnt", 32'(gnt_id), 32'h2);
    check_eq("bp_d1",  32'(wdata), 32'hB1);
    tick();
    set_data(2, 8'hB2);
    #1;
    check_eq("bp_w2", 32'(winc), 32'h1);
    check_eq("bp_d2", 32'(wdata), 32'hB2);
    tick();
    set_data(2, 8'hB3);
    wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      check_eq("bp_full_winc",  32'(winc), 32'h0);
      check_eq("bp_full_ready", 32'(req_ready), 32'h0);
      check_eq("bp_full_busy",  32'(busy), 32'h1);
      check_eq("bp_full_wdata", 32'(wdata), 32'hB3);
      check_eq("bp_full_cnt",   32'(wr_count), 32'h2);
    end
    tick();
    wfull = 1'b0;
    #1;
    check_eq("bp_w3",     32'(winc), 32'h1);
    check_eq("bp_d3",     32'(wdata), 32'hB3);
    check_eq("bp_ready3", 32'(req_ready), 32'h4);
    tick();
    set_data(2, 8'hB4);
    req_last[2] = 1'b1;
    #1;
    check_eq("bp_w4", 32'(winc), 32'h1);
    check_eq("bp_d4", 32'(wdata), 32'hB4);
    check_eq("bp_c3", 32'(wr_count), 32'h3);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check_eq("bp_cnt",  32'(wr_count), 32'h4);
    check_eq("bp_busy", 32'(busy), 32'h0);

    // Mid-packet reset: last grantee was 2, so requester 3 wins over 0.
    req_valid = 4'b1001;
    set_data(3, 8'hC1);
    set_data(0, 8'hD0);
    tick();
    #1;
    check_eq("mr_gnt3", 32'(gnt_id), 32'h3);
    check_eq("mr_d1",   32'(wdata), 32'hC1);
    tick();
    set_data(3, 8'hC2);
    #1;
    check_eq("mr_c5", 32'(wr_count), 32'h5);
    tick();
    set_data(3, 8'hC3);
    #1;
    check_eq("mr_c6", 32'(wr_count), 32'h6);
    wrst_n = 1'b0;
    #1;
    check_eq("mr_winc",  32'(winc), 32'h0);
    check_eq("mr_ready", 32'(req_ready), 32'h0);
    check_eq("mr_busy",  32'(busy), 32'h0);
    check_eq("mr_gnt",   32'(gnt_id), 32'h0);
    check_eq("mr_cnt",   32'(wr_count), 32'h0);
    #1;
    wrst_n = 1'b1;
    tick();
    #1;
    check_eq("mr_regnt",  32'(gnt_id), 32'h0);
    check_eq("mr_rebusy", 32'(busy), 32'h1);
    check_eq("mr_rewd",   32'(wdata), 32'hD0);
    req_valid = '0;
    do_reset();

    // Counter wrap: one long packet from requester 1, one word per cycle.
    req_valid[1] = 1'b1;
    set_data(1, 8'h55);
    tick();
    repeat (65535) @(posedge wclk);
    #1;
    check_eq("wrap_ffff", 32'(wr_count), 32'hFFFF);
    tick();
    check_eq("wrap_zero", 32'(wr_count), 32'h0);
    check_eq("wrap_winc", 32'(winc), 32'h1);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
